// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared constants and the pointer-width helper for the BE-side fe_queue buffer.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
package bp_be_fe_queue_buffer_pkg;

    localparam int fe_queue_width_lp = 64;
    localparam int fe_queue_els_lp   = 8;

    function automatic int bp_be_fe_queue_ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bp_be_fe_queue_buffer_mem.sv
// els_p x width_p register file: one synchronous write port, one asynchronous read port.
// Data is never reset; a write lands on the clock edge and is visible to reads after it.
module bp_be_fe_queue_buffer_mem #(
    parameter int els_p     = 8,
    parameter int width_p   = 64,
    parameter int addr_w_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 w_v_i,
    input  logic [addr_w_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic [addr_w_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            r_mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_mem[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// Checkpointed circular FIFO holding FE messages until BE commits them; roll rewinds, clr flushes.
// Enqueue to valid: 1 cycle, no bypass. Ready drops when full; a same-cycle deq does not reopen it.
module bp_be_fe_queue_buffer
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter int els_p   = fe_queue_els_lp,
    parameter int width_p = fe_queue_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               deq_v_i,
    input  logic               roll_v_i,
    input  logic               clr_v_i,
    output logic               empty_o
);

    localparam int ptr_w_lp = bp_be_fe_queue_ptr_width(els_p);
    localparam int idx_w_lp = ptr_w_lp - 1;
    localparam logic [ptr_w_lp-1:0] one_lp = ptr_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] els_lp = ptr_w_lp'(els_p);

    logic [ptr_w_lp-1:0] r_wptr, r_rptr, r_cptr;
    logic [ptr_w_lp-1:0] w_wptr_n, w_rptr_n, w_cptr_n;
    logic [ptr_w_lp-1:0] w_occ, w_rd_ahead;
    logic                w_full, w_enq;

    assign w_occ      = r_wptr - r_cptr;
    assign w_rd_ahead = r_rptr - r_cptr;
    assign w_full     = (w_occ == els_lp);
    assign w_enq      = fe_queue_v_i & ~w_full & ~clr_v_i;

    assign fe_queue_ready_o = ~w_full;
    assign fe_queue_v_o     = (r_rptr != r_wptr) & ~roll_v_i & ~clr_v_i;
    assign empty_o          = (r_wptr == r_cptr);

    // Commit is applied before any rewind, so a deq alongside roll/clr stays committed.
    assign w_cptr_n = r_cptr + (deq_v_i ? one_lp : '0);

    always_comb begin
        w_rptr_n = r_rptr;
        if (clr_v_i || roll_v_i) begin
            w_rptr_n = w_cptr_n;
        end else if (fe_queue_yumi_i) begin
            w_rptr_n = r_rptr + one_lp;
        end
    end

    always_comb begin
        w_wptr_n = r_wptr;
        if (clr_v_i) begin
            w_wptr_n = w_cptr_n;
        end else if (w_enq) begin
            w_wptr_n = r_wptr + one_lp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cptr <= '0;
        end else begin
            r_wptr <= w_wptr_n;
            r_rptr <= w_rptr_n;
            r_cptr <= w_cptr_n;
        end
    end

    bp_be_fe_queue_buffer_mem #(
        .els_p   (els_p),
        .width_p (width_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_enq),
        .w_addr_i (r_wptr[idx_w_lp-1:0]),
        .w_data_i (fe_queue_i),
        .r_addr_i (r_rptr[idx_w_lp-1:0]),
        .r_data_o (fe_queue_o)
    );

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        fe_queue_yumi_i |-> fe_queue_v_o);
    a_deq_needs_read: assert property (@(posedge clk_i) disable iff (reset_i)
        deq_v_i |-> ((r_cptr != r_rptr) || fe_queue_yumi_i));
    a_ptr_order: assert property (@(posedge clk_i) disable iff (reset_i)
        (w_rd_ahead <= w_occ) && (w_occ <= els_lp));
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Directed bench for bp_be_fe_queue_buffer: ordering, full, roll, clr, wrap-around, mid-op reset.
module tb_bp_be_fe_queue_buffer;

    localparam int W = 32;
    localparam int N = 8;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [W-1:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         fe_queue_ready_o;
    logic [W-1:0] fe_queue_o;
    logic         fe_queue_v_o;
    logic         fe_queue_yumi_i;
    logic         deq_v_i;
    logic         roll_v_i;
    logic         clr_v_i;
    logic         empty_o;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk_i = ~clk_i;

    bp_be_fe_queue_buffer #(.els_p(N), .width_p(W)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .deq_v_i          (deq_v_i),
        .roll_v_i         (roll_v_i),
        .clr_v_i          (clr_v_i),
        .empty_o          (empty_o)
    );

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        deq_v_i         = 1'b0;
        roll_v_i        = 1'b0;
        clr_v_i         = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            fe_queue_v_i = 1'b1;
            fe_queue_i   = base + W'(i);
            nxt();
        end
        fe_queue_v_i = 1'b0;
    endtask

    task automatic yumi_n(input int n, input logic [W-1:0] base, input string tag);
        for (int i = 0; i < n; i++) begin
            fe_queue_yumi_i = 1'b1;
            #1;
            check({tag, "_v"}, W'(fe_queue_v_o), 1);
            check({tag, "_dat"}, fe_queue_o, base + W'(i));
            nxt();
        end
        fe_queue_yumi_i = 1'b0;
    endtask

    task automatic deq_n(input int n);
        for (int i = 0; i < n; i++) begin
            deq_v_i = 1'b1;
            nxt();
        end
        deq_v_i = 1'b0;
    endtask

    initial begin
        int np, nr, nc, cyc;
        logic exp_v, exp_rdy;

        idle();
        fe_queue_i = '0;
        reset_i    = 1'b1;
        nxt();
        nxt();
        check("rst_ready", W'(fe_queue_ready_o), 1);
        check("rst_v",     W'(fe_queue_v_o), 0);
        check("rst_empty", W'(empty_o), 1);
        reset_i = 1'b0;
        nxt();

        // 1: A,B,C in order, one-cycle latency, empty until three commits
        fe_queue_v_i = 1'b1; fe_queue_i = 32'hA;
        #1; check("t1_no_bypass", W'(fe_queue_v_o), 0);
        nxt();
        fe_queue_i = 32'hB; fe_queue_yumi_i = 1'b1;
        #1; check("t1_v_a", W'(fe_queue_v_o), 1); check("t1_dat_a", fe_queue_o, 32'hA);
        nxt();
        fe_queue_i = 32'hC;
        #1; check("t1_dat_b", fe_queue_o, 32'hB);
        nxt();
        fe_queue_v_i = 1'b0;
        #1; check("t1_dat_c", fe_queue_o, 32'hC); check("t1_empty_rd", W'(empty_o), 0);
        nxt();
        fe_queue_yumi_i = 1'b0;
        #1; check("t1_drained_v", W'(fe_queue_v_o), 0);
        for (int i = 0; i < 3; i++) begin
            deq_v_i = 1'b1;
            #1; check("t1_not_empty", W'(empty_o), 0);
            nxt();
        end
        deq_v_i = 1'b0;
        #1; check("t1_empty", W'(empty_o), 1);

        // 2: fill to els_p, extra push refused, reopen one cycle after a deq
        for (int i = 0; i < N; i++) begin
            fe_queue_v_i = 1'b1; fe_queue_i = 32'h10 + W'(i);
            #1; check("t2_ready_fill", W'(fe_queue_ready_o), 1);
            nxt();
        end
        fe_queue_i = 32'hDEAD;
        #1; check("t2_full", W'(fe_queue_ready_o), 0);
        nxt();
        fe_queue_v_i = 1'b0;
        yumi_n(N, 32'h10, "t2_rd");
        #1; check("t2_no_ninth", W'(fe_queue_v_o), 0);
        deq_v_i = 1'b1;
        #1; check("t2_no_deq_bypass", W'(fe_queue_ready_o), 0);
        nxt();
        deq_v_i = 1'b0;
        #1; check("t2_reopen", W'(fe_queue_ready_o), 1);
        deq_n(N - 1);
        #1; check("t2_empty", W'(empty_o), 1);

        // 3: roll re-presents from the commit point
        push_n(5, 32'h20);
        yumi_n(4, 32'h20, "t3_rd");
        deq_n(2);
        roll_v_i = 1'b1;
        #1; check("t3_roll_v", W'(fe_queue_v_o), 0);
        nxt();
        roll_v_i = 1'b0;
        yumi_n(3, 32'h22, "t3_replay");
        #1; check("t3_after_v", W'(fe_queue_v_o), 0);
        deq_n(3);
        #1; check("t3_empty", W'(empty_o), 1);

        // 4: clr drops uncommitted entries and a coincident push
        push_n(5, 32'h30);
        yumi_n(3, 32'h30, "t4_rd");
        deq_n(1);
        clr_v_i = 1'b1; fe_queue_v_i = 1'b1; fe_queue_i = 32'h99;
        #1; check("t4_clr_v", W'(fe_queue_v_o), 0);
        nxt();
        clr_v_i = 1'b0; fe_queue_v_i = 1'b0;
        #1; check("t4_post_v", W'(fe_queue_v_o), 0); check("t4_post_empty", W'(empty_o), 1);
        fe_queue_v_i = 1'b1; fe_queue_i = 32'h55;
        #1; check("t4_push_lat", W'(fe_queue_v_o), 0);
        nxt();
        fe_queue_v_i = 1'b0;
        yumi_n(1, 32'h55, "t4_new");
        deq_n(1);
        #1; check("t4_empty", W'(empty_o), 1);

        // 5: steady-state traffic with random stalls, wraps the ring several times
        np = 0; nr = 0; nc = 0; cyc = 0;
        while (nc < 3 * N && cyc < 3000) begin
            fe_queue_v_i = (np < 3 * N) && ($urandom_range(0, 3) != 0);
            fe_queue_i   = 32'h1000 + W'(np);
            #1;
            exp_v   = (nr < np);
            exp_rdy = ((np - nc) < N);
            check("t5_v",     W'(fe_queue_v_o), W'(exp_v));
            check("t5_ready", W'(fe_queue_ready_o), W'(exp_rdy));
            check("t5_empty", W'(empty_o), W'(np == nc));
            if (exp_v) check("t5_dat", fe_queue_o, 32'h1000 + W'(nr));
            fe_queue_yumi_i = exp_v && ($urandom_range(0, 1) == 1);
            deq_v_i = ((nc < nr) || fe_queue_yumi_i) && ($urandom_range(0, 2) != 0);
            if (fe_queue_v_i && exp_rdy) np++;
            if (fe_queue_yumi_i) nr++;
            if (deq_v_i) nc++;
            nxt();
            cyc++;
        end
        idle();
        check("t5_all_committed", W'(nc), W'(3 * N));
        #1; check("t5_end_empty", W'(empty_o), 1);

        // 6: reset while holding entries with deq/roll/yumi active
        push_n(6, 32'h60);
        yumi_n(2, 32'h60, "t6_rd");
        reset_i = 1'b1; deq_v_i = 1'b1; roll_v_i = 1'b1; fe_queue_yumi_i = 1'b1;
        nxt();
        reset_i = 1'b0;
        idle();
        #1;
        check("t6_ready", W'(fe_queue_ready_o), 1);
        check("t6_v",     W'(fe_queue_v_o), 0);
        check("t6_empty", W'(empty_o), 1);
        push_n(1, 32'h77);
        yumi_n(1, 32'h77, "t6_new");
        deq_n(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
